write_control_ext: RTL

Parametrised write-side controller for the asynchronous FIFO, running entirely in the write clock domain. It owns the binary and Gray write pointers and synchronises the read-domain Gray pointer through a configurable flop chain. From these it derives full, programmable almost-full, occupancy, free-space and sticky overflow status. It sits between the write client and the dual-port RAM / read controller, and replaces the fixed-function write controller.

---
 rtl/write_control_ext.sv | 99 +++++++++
 1 files changed

// File: rtl/write_control_ext.sv
// Write-side async FIFO controller: binary/Gray write pointers, read-pointer synchroniser, full/afull/level/free/overflow status.
// Latency: a write is reflected in the status right after its edge; a read-pointer change is seen SYNC_STAGES edges later.
// Backpressure: w_wen is gated by w_full, so requests made while full are dropped and recorded in the sticky w_overflow.
module write_control_ext #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  w_req,
    input  logic                  w_ovf_clr,
    input  logic [ADDR_WIDTH:0]   r_g_addr,
    output logic                  w_wen,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   w_g_addr,
    output logic                  w_full,
    output logic                  w_afull,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic [ADDR_WIDTH:0]   w_free,
    output logic                  w_overflow
);

    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] DEPTH_V = AW1'(1 << ADDR_WIDTH);
    localparam logic [AW1-1:0] AFULL_V = AW1'(AFULL_LEVEL);

    logic [AW1-1:0] w_bin;
    logic [AW1-1:0] w_bin_nxt;
    logic [AW1-1:0] sync [SYNC_STAGES];
    logic [AW1-1:0] r_sync;
    logic [AW1-1:0] r_bin_sync;
    logic           ovf;
    logic           full_gray;

    function automatic logic [AW1-1:0] gray2bin(input logic [AW1-1:0] g);
        logic [AW1-1:0] b;
        b[AW1-1] = g[AW1-1];
        for (int i = AW1 - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Status derived purely from registered pointers; the read side is seen through the synchroniser only.
    always_comb begin
        r_sync     = sync[SYNC_STAGES-1];
        r_bin_sync = gray2bin(r_sync);
        w_level    = w_bin - r_bin_sync;
        w_full     = (w_level == DEPTH_V);
        w_afull    = (w_level >= AFULL_V);
        w_free     = DEPTH_V - w_level;
        w_wen      = w_req & ~w_full & w_rst;
        w_addr     = w_bin[ADDR_WIDTH-1:0];
        w_bin_nxt  = w_bin + AW1'(1);
        w_overflow = ovf;
        full_gray  = (w_g_addr == {~r_sync[AW1-1:AW1-2], r_sync[AW1-3:0]});
    end

    // Write pointer pair: the Gray copy is registered so the read domain only ever sees single-bit steps.
    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            w_bin    <= '0;
            w_g_addr <= '0;
        end else if (w_wen) begin
            w_bin    <= w_bin_nxt;
            w_g_addr <= w_bin_nxt ^ (w_bin_nxt >> 1);
        end
    end

    // Read Gray pointer synchroniser chain.
    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync[i] <= '0;
            end
        end else begin
            sync[0] <= r_g_addr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    // Sticky overflow: a request while full sets it; a coincident clear loses to the set.
    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            ovf <= 1'b0;
        end else if (w_req && w_full) begin
            ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // The level-based and Gray-compare forms of full must always agree.
    full_forms_agree: assert property (@(posedge w_clk) w_full == full_gray);

endmodule
